// File: rtl/mod_instruction_fetch.sv
// Instruction fetch stage: owns the program counter, drives the combinational
// instruction ROM and captures each fetched word into the IF/ID register.
// Handles stall, redirect with a single squashed slot, and a sticky halt at
// the end of program memory.
// Optional build macro: FETCH_PERF_COUNT_EN adds fetch_count / stall_count.
module mod_instruction_fetch #(
    parameter logic [29:0] RESET_PC = 30'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [29:0] redirect_target,
    output logic [29:0] rom_address,
    input  logic [31:0] rom_instruction,
    input  logic        rom_mem_end,
    output logic [31:0] if_instruction,
    output logic [29:0] if_pc,
    output logic [29:0] if_pc_plus1,
    output logic        if_valid,
    output logic        halted
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state;
    state_t      state_next;
    logic [29:0] pc;
    logic [29:0] pc_next;
    logic        valid_next;
    logic        load_if;
    logic        stall_run;

    // Word-address increment; wraps naturally modulo 2^30.
    function automatic logic [29:0] pc_inc(input logic [29:0] p);
        return p + 30'd1;
    endfunction

    assign rom_address = pc;
    assign if_pc_plus1 = pc_inc(if_pc);
    assign halted      = (state == HALT);

    // Next-state decode: redirect beats halt, halt beats stall, stall beats fetch.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        valid_next = if_valid;
        load_if    = 1'b0;
        stall_run  = 1'b0;
        if (redirect_valid) begin
            pc_next    = redirect_target;
            valid_next = 1'b0;
            state_next = RUN;
        end else if (state == HALT) begin
            valid_next = 1'b0;
        end else if (stall) begin
            stall_run  = 1'b1;
        end else if (rom_mem_end) begin
            valid_next = 1'b0;
            state_next = HALT;
        end else begin
            load_if    = 1'b1;
            valid_next = 1'b1;
            pc_next    = pc_inc(pc);
        end
    end

    // PC, fetch state and IF/ID register update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= RUN;
            pc             <= RESET_PC;
            if_valid       <= 1'b0;
            if_instruction <= 32'd0;
            if_pc          <= 30'd0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            if_valid <= valid_next;
            if (load_if) begin
                if_instruction <= rom_instruction;
                if_pc          <= pc;
            end
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    // Performance counters: valid IF/ID loads and stalled RUN cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (load_if)   fetch_count <= fetch_count + 32'd1;
            if (stall_run) stall_count <= stall_count + 32'd1;
        end
    end
`else
    // Counters not built; stall_run only feeds them.
    logic unused_stall_run;
    assign unused_stall_run = stall_run;
`endif

endmodule

// File: tb/tb_mod_instruction_fetch.sv
// Directed testbench for mod_instruction_fetch with a behavioural ROM model.
module tb_mod_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [29:0] redirect_target;
    logic [29:0] rom_address;
    logic [31:0] rom_instruction;
    logic        rom_mem_end;
    logic [31:0] if_instruction;
    logic [29:0] if_pc;
    logic [29:0] if_pc_plus1;
    logic        if_valid;
    logic        halted;
`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int checks   = 0;
    int failures = 0;
    int rom_len  = 23;

    mod_instruction_fetch #(.RESET_PC(30'd0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .rom_address     (rom_address),
        .rom_instruction (rom_instruction),
        .rom_mem_end     (rom_mem_end),
        .if_instruction  (if_instruction),
        .if_pc           (if_pc),
        .if_pc_plus1     (if_pc_plus1),
        .if_valid        (if_valid),
        .halted          (halted)
`ifdef FETCH_PERF_COUNT_EN
        ,
        .fetch_count     (fetch_count),
        .stall_count     (stall_count)
`endif
    );

    always #5 clk = ~clk;

    // ROM: word0/word1 fixed, others 0xA0000000|addr, top word 0xDEADBEEF.
    always_comb begin
        rom_instruction = 32'd0;
        rom_mem_end     = 1'b0;
        if (rom_address == 30'h3FFFFFFF) begin
            rom_instruction = 32'hDEADBEEF;
        end else if (rom_address >= 30'(rom_len)) begin
            rom_mem_end = 1'b1;
        end else if (rom_address == 30'd0) begin
            rom_instruction = 32'h20010001;
        end else if (rom_address == 30'd1) begin
            rom_instruction = 32'h00011020;
        end else begin
            rom_instruction = 32'hA0000000 | {2'b00, rom_address};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input logic [29:0] addr, input int budget);
        int n = 0;
        while (rom_address != addr && n < budget) begin
            step();
            n++;
        end
        check("reach_addr", {2'b00, rom_address}, {2'b00, addr});
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 30'd0;
        step(); step();
        check("rst_addr", {2'b00, rom_address}, 32'd0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_instr", if_instruction, 32'd0);
        check("rst_pc", {2'b00, if_pc}, 32'd0);
        rst_n = 1'b1;

        // First two fetches
        step();
        check("e1_instr", if_instruction, 32'h20010001);
        check("e1_pc", {2'b00, if_pc}, 32'd0);
        check("e1_plus1", {2'b00, if_pc_plus1}, 32'd1);
        check("e1_valid", {31'd0, if_valid}, 32'd1);
        step();
        check("e2_instr", if_instruction, 32'h00011020);
        check("e2_pc", {2'b00, if_pc}, 32'd1);

        // Stall three cycles at PC=5
        run_until(30'd5, 10);
        stall = 1'b1;
        step(); step(); step();
        check("stl_addr", {2'b00, rom_address}, 32'd5);
        check("stl_instr", if_instruction, 32'hA0000004);
        check("stl_pc", {2'b00, if_pc}, 32'd4);
        check("stl_valid", {31'd0, if_valid}, 32'd1);
`ifdef FETCH_PERF_COUNT_EN
        check("stl_scnt", stall_count, 32'd3);
        check("stl_fcnt", fetch_count, 32'd5);
`endif
        stall = 1'b0;
        step();
        check("rel_instr", if_instruction, 32'hA0000005);
        check("rel_pc", {2'b00, if_pc}, 32'd5);

        // Redirect at PC=15 to 7
        run_until(30'd15, 20);
        redirect_valid = 1'b1; redirect_target = 30'd7;
        step();
        check("rd_addr", {2'b00, rom_address}, 32'd7);
        check("rd_valid", {31'd0, if_valid}, 32'd0);
        redirect_valid = 1'b0;
        step();
        check("rd_pc", {2'b00, if_pc}, 32'd7);
        check("rd_instr", if_instruction, 32'hA0000007);
        check("rd_valid2", {31'd0, if_valid}, 32'd1);

        // Redirect and stall together at PC=12
        run_until(30'd12, 20);
        redirect_valid = 1'b1; redirect_target = 30'd7; stall = 1'b1;
        step();
        check("rs_addr", {2'b00, rom_address}, 32'd7);
        check("rs_valid", {31'd0, if_valid}, 32'd0);
        redirect_valid = 1'b0; stall = 1'b0;
        step();
        check("rs_pc", {2'b00, if_pc}, 32'd7);
        check("rs_valid2", {31'd0, if_valid}, 32'd1);

        // Run to end of memory
        run_until(30'd23, 40);
        check("end_pc", {2'b00, if_pc}, 32'd22);
        check("end_instr", if_instruction, 32'hA0000016);
        check("end_valid", {31'd0, if_valid}, 32'd1);
        check("end_halted0", {31'd0, halted}, 32'd0);
        step();
        check("hlt_valid", {31'd0, if_valid}, 32'd0);
        check("hlt_halted", {31'd0, halted}, 32'd1);
        check("hlt_addr", {2'b00, rom_address}, 32'd23);
        stall = 1'b1;
        step(); step();
        stall = 1'b0;
        step(); step();
        check("hlt_hold", {2'b00, rom_address}, 32'd23);
        check("hlt_sticky", {31'd0, halted}, 32'd1);
        check("hlt_valid2", {31'd0, if_valid}, 32'd0);
`ifdef FETCH_PERF_COUNT_EN
        check("hlt_scnt", stall_count, 32'd3);
`endif
        redirect_valid = 1'b1; redirect_target = 30'd0;
        step();
        check("res_halted", {31'd0, halted}, 32'd0);
        check("res_addr", {2'b00, rom_address}, 32'd0);
        redirect_valid = 1'b0;
        step();
        check("res_instr", if_instruction, 32'h20010001);
        check("res_valid", {31'd0, if_valid}, 32'd1);

        // PC wrap at top of address space
        redirect_valid = 1'b1; redirect_target = 30'h3FFFFFFF;
        step();
        check("wr_addr", {2'b00, rom_address}, 32'h3FFFFFFF);
        redirect_valid = 1'b0;
        step();
        check("wr_pc", {2'b00, if_pc}, 32'h3FFFFFFF);
        check("wr_instr", if_instruction, 32'hDEADBEEF);
        check("wr_plus1", {2'b00, if_pc_plus1}, 32'd0);
        check("wr_next", {2'b00, rom_address}, 32'd0);

        // Reset while stalled
        step(); step();
        stall = 1'b1; rst_n = 1'b0;
        step();
        check("rs2_addr", {2'b00, rom_address}, 32'd0);
        check("rs2_valid", {31'd0, if_valid}, 32'd0);
        check("rs2_instr", if_instruction, 32'd0);
`ifdef FETCH_PERF_COUNT_EN
        check("rs2_fcnt", fetch_count, 32'd0);
        check("rs2_scnt", stall_count, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod_instruction_fetch.md
# mod_instruction_fetch

Instruction fetch stage that owns the program counter and drives the word address of the combinational instruction ROM. It captures each returned instruction into an IF/ID pipeline register for the decode stage. It supports stall, branch/jump redirect with wrong-path squash, and halts cleanly when the ROM flags end of program memory.

## Interface
- RESET_PC, 0, word address loaded into the PC on reset (30 bits).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  decode/hazard hold; freezes PC and IF/ID register.
- redirect_valid  in  1  branch/jump resolved taken this cycle.
- redirect_target  in  30  word address of the new fetch target.
- rom_address  out  30  word address to ROM; combinational copy of the PC.
- rom_instruction  in  32  ROM data for rom_address (same cycle).
- rom_mem_end  in  1  ROM flag: rom_address is past the last program word.
- if_instruction  out  32  IF/ID instruction register.
- if_pc  out  30  word address of if_instruction.
- if_pc_plus1  out  30  if_pc + 1, for link/branch-offset use.
- if_valid  out  1  IF/ID register holds a real instruction.
- halted  out  1  sticky; fetch stopped at end of memory.

## Operation
- State: PC (30 b), IF/ID {instruction, pc, valid}, halted flag. Two fetch states: RUN (halted=0) and HALT (halted=1).
- rom_address = PC at all times; no ROM latency assumed.
- Per-edge priority: reset > redirect_valid > halted > stall > normal fetch.
- Normal fetch (RUN, no stall, no redirect, rom_mem_end=0): IF/ID <= {rom_instruction, PC, 1}; PC <= PC+1.
- End of memory (RUN, no stall, no redirect, rom_mem_end=1): if_valid <= 0; PC held; halted <= 1 (RUN->HALT).
- Stall (no redirect): PC, IF/ID and halted all hold; if_valid keeps its value.
- Redirect (regardless of stall or halted): PC <= redirect_target; if_valid <= 0, squashing the instruction fetched this cycle; halted <= 0 (HALT->RUN). if_instruction/if_pc may hold stale values when if_valid=0.
- HALT, no redirect: PC holds; if_valid <= 0; stall is irrelevant.
- PC+1 wraps modulo 2^30 (0x3FFFFFFF -> 0). if_pc_plus1 wraps identically.
- Any instruction value, including 0, is fetched as data; no decode is done here.

## Timing
- Reset (rst_n=0 at an edge): PC=RESET_PC, if_instruction=0, if_pc=0, if_valid=0, halted=0. Reset mid-stall or mid-halt gives the same result. Counters (if built) are cleared.
- Fetch latency: the instruction at address A appears on if_instruction one edge after PC=A.
- Redirect latency: the first edge after the redirect edge delivers the instruction at redirect_target with if_valid=1, unless stalled. There is exactly one squashed slot.
- stall and redirect in the same cycle: redirect wins and the stall is ignored for that edge.
- After the last valid word, if_valid drops on the same edge that halted rises.

## Configuration
- FETCH_PERF_COUNT_EN defined: adds outputs fetch_count (32 b) and stall_count (32 b).
  - fetch_count increments on every edge that loads IF/ID with valid=1.
  - stall_count increments on every edge with stall=1 in RUN without redirect.
  - Both reset to 0 and wrap at 2^32.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset with RESET_PC=0 and ROM word0=0x20010001, word1=0x00011020 -> after reset, rom_address=0 and if_valid=0. Edge 1: if_instruction=0x20010001, if_pc=0, if_pc_plus1=1, if_valid=1. Edge 2: 0x00011020, if_pc=1.
- stall=1 for 3 cycles while PC=5 -> rom_address stays 5 and IF/ID holds the address-4 instruction unchanged. The edge after release delivers the address-5 instruction. With the macro on, stall_count=3.
- redirect_valid=1, target=7, while PC=15 -> next edge: PC=7, if_valid=0. Following edge: if_pc=7, if_valid=1. The instruction at 15 is never seen with valid=1.
- redirect and stall together at PC=12, target=7 -> redirect takes effect with PC=7 and if_valid=0, and the stall is ignored.
- ROM with 23 words run to the end -> the address-22 instruction is delivered valid. Next edge: if_valid=0, halted=1, rom_address=23 held indefinitely. Then redirect target=0 -> halted=0 and fetch resumes at 0.
- PC forced by redirect to 0x3FFFFFFF with a ROM returning 0xDEADBEEF -> if_pc=0x3FFFFFFF, if_pc_plus1=0, and the next rom_address=0.
